// File: rtl/mdio_pkg.sv
// Shared constants and FSM encoding for the MDIO peripheral and its helpers.
// A frame is {ST, OP, PHYAD, REGAD, TA, DATA}: 32 bits, sent MSB first.
package mdio_pkg;

  localparam logic [1:0] ST_BITS = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;

  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int TA_W    = 2;
  localparam int DATA_W  = 16;
  localparam int FRAME_W = 32;
  localparam int REG_W   = 16;

  // Index of the last frame bit belonging to each field (ST occupies bits 0..1).
  localparam logic [4:0] IDX_OP_END  = 5'd3;
  localparam logic [4:0] IDX_PHY_END = 5'd8;
  localparam logic [4:0] IDX_REG_END = 5'd13;
  localparam logic [4:0] IDX_TA1     = 5'd14;
  localparam logic [4:0] IDX_TA_END  = 5'd15;
  localparam logic [4:0] IDX_LAST    = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OP     = 3'd1,
    S_PHYAD  = 3'd2,
    S_REGAD  = 3'd3,
    S_TA     = 3'd4,
    S_WDATA  = 3'd5,
    S_RDATA  = 3'd6,
    S_IGNORE = 3'd7
  } state_t;

endpackage

// File: rtl/mdio_edge_det.sv
// MDC edge detector: registers MDC once per CLK and flags single-cycle rise/fall.
// MDC is CLK-synchronous, so no synchronizer stage is needed.
module mdio_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic mdc,
  output logic rise,
  output logic fall
);

  logic mdc_q;

  always_ff @(posedge clk) begin
    if (!reset_n) mdc_q <= 1'b0;
    else          mdc_q <= mdc;
  end

  assign rise = mdc & ~mdc_q;
  assign fall = ~mdc & mdc_q;

endmodule

// File: rtl/mdio_peripheral.sv
// PHY-side MDIO responder: deframes controller frames, strobes writes, serves reads.
// Define MDIO_PREAMBLE_EN to require 32 consecutive ones before ST is accepted.
// Handshake: WR_STB/RD_STB are single-CLK pulses with no back-pressure; RD_DATA
// must be valid the CLK after RD_STB and is captured one CLK later.
module mdio_peripheral
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             MDC,
  input  logic             MDIO_OUT,
  input  logic             MDIO_OE,
  output logic             MDIO_IN,
  output logic             MDIO_IN_OE,
  output logic [4:0]       ADDR,
  output logic [REG_W-1:0] WR_DATA,
  output logic             WR_STB,
  output logic             RD_STB,
  input  logic [REG_W-1:0] RD_DATA,
  output logic             BUS_COLL,
  output state_t           dbg_state
);

  logic             rise, fall;
  state_t           state, state_nx;
  logic [4:0]       cnt, cnt_nx, idx;
  logic             last_bit;
  logic [REG_W-1:0] rx_sh, tx_sh, new_bits;
  logic             is_rd, rd_cap, pre_ok, st_hit;
  logic             op_load, addr_load, rd_req, wr_load, ta_drive, shift_out, drop_oe;

  mdio_edge_det u_edge (
    .clk     (CLK),
    .reset_n (RESET),
    .mdc     (MDC),
    .rise    (rise),
    .fall    (fall)
  );

  // idx is the frame position of the bit being sampled on this rise.
  assign idx       = cnt + 5'd1;
  assign new_bits  = {rx_sh[REG_W-2:0], MDIO_OUT};
  assign st_hit    = (state == S_IDLE) && rise && ({last_bit, MDIO_OUT} == ST_BITS) && pre_ok;
  assign dbg_state = state;

`ifdef MDIO_PREAMBLE_EN
  logic [5:0] pre_cnt;
  logic       pre_ok_q;

  // pre_ok_q latches "32 ones were seen" on the 0 that starts ST.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pre_cnt  <= 6'd0;
      pre_ok_q <= 1'b0;
    end else if (rise && state == S_IDLE) begin
      if (MDIO_OUT) begin
        if (pre_cnt != 6'd32) pre_cnt <= pre_cnt + 6'd1;
        if (st_hit) pre_ok_q <= 1'b0;
      end else begin
        pre_ok_q <= (pre_cnt == 6'd32);
        pre_cnt  <= 6'd0;
      end
    end
  end

  assign pre_ok = pre_ok_q;
`else
  assign pre_ok = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= S_IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (st_hit) begin
          state_nx = S_OP;
          cnt_nx   = 5'd1;
        end
      end
      S_OP: begin
        if (rise) begin
          cnt_nx = idx;
          if (idx == IDX_OP_END)
            state_nx = (new_bits[1:0] == OP_WR || new_bits[1:0] == OP_RD) ? S_PHYAD : S_IGNORE;
        end
      end
      S_PHYAD: begin
        if (rise) begin
          cnt_nx = idx;
          if (idx == IDX_PHY_END)
            state_nx = (new_bits[4:0] == PHY_ADDR) ? S_REGAD : S_IGNORE;
        end
      end
      S_REGAD: begin
        if (rise) begin
          cnt_nx = idx;
          if (idx == IDX_REG_END) state_nx = S_TA;
        end
      end
      S_TA: begin
        if (rise) begin
          cnt_nx = idx;
          if (idx == IDX_TA_END) state_nx = is_rd ? S_RDATA : S_WDATA;
        end
      end
      // Read frames stay in RDATA until the fall after the last rise releases the bus.
      S_RDATA: begin
        if (rise && cnt != IDX_LAST) cnt_nx = idx;
        if (fall && cnt == IDX_LAST) begin
          state_nx = S_IDLE;
          cnt_nx   = 5'd0;
        end
      end
      S_WDATA, S_IGNORE: begin
        if (rise) begin
          if (idx == IDX_LAST) begin
            state_nx = S_IDLE;
            cnt_nx   = 5'd0;
          end else begin
            cnt_nx = idx;
          end
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = 5'd0;
      end
    endcase
  end

  always_comb begin
    op_load   = (state == S_OP) && rise && (idx == IDX_OP_END);
    addr_load = (state == S_REGAD) && rise && (idx == IDX_REG_END);
    rd_req    = addr_load && is_rd;
    wr_load   = (state == S_WDATA) && rise && (idx == IDX_LAST);
    ta_drive  = (state == S_TA) && fall && is_rd && (cnt == IDX_TA1);
    shift_out = (state == S_RDATA) && fall && (cnt >= IDX_TA_END) && (cnt < IDX_LAST);
    drop_oe   = (state == S_RDATA) && fall && (cnt == IDX_LAST);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      last_bit   <= 1'b1;
      rx_sh      <= '0;
      tx_sh      <= '0;
      is_rd      <= 1'b0;
      rd_cap     <= 1'b0;
      ADDR       <= 5'd0;
      WR_DATA    <= '0;
      WR_STB     <= 1'b0;
      RD_STB     <= 1'b0;
      MDIO_IN    <= 1'b0;
      MDIO_IN_OE <= 1'b0;
      BUS_COLL   <= 1'b0;
    end else begin
      WR_STB   <= wr_load;
      RD_STB   <= rd_req;
      rd_cap   <= RD_STB;
      BUS_COLL <= BUS_COLL | (MDIO_OE & MDIO_IN_OE);
      if (rise) rx_sh <= new_bits;
      if (rise && state == S_IDLE) last_bit <= MDIO_OUT;
      if (op_load) is_rd <= (new_bits[1:0] == OP_RD);
      if (addr_load) ADDR <= new_bits[4:0];
      if (wr_load) WR_DATA <= new_bits;
      if (rd_cap) begin
        tx_sh <= RD_DATA;
      end else if (shift_out) begin
        tx_sh <= {tx_sh[REG_W-2:0], 1'b0};
      end
      if (ta_drive) begin
        MDIO_IN_OE <= 1'b1;
        MDIO_IN    <= 1'b0;
      end else if (shift_out) begin
        MDIO_IN <= tx_sh[REG_W-1];
      end else if (drop_oe) begin
        MDIO_IN_OE <= 1'b0;
        MDIO_IN    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mdio_peripheral.md
Name: mdio_peripheral

Overview:
PHY-side responder for the MDIO management interface, the far end of mdio_controller. Watches MDC/MDIO_OUT from the controller, deframes 32-bit Clause-22-style frames {ST=01, OP, PHYAD, REGAD, TA, DATA}, issues register-file write strobes, and serves reads by driving MDIO_IN back. It is used as the bus model/responder in MDIO integration benches and as the register-access front end of the PHY model.

Parameters:
PHY_ADDR, 5'd1, PHY address this instance answers to.
REG_W, 16, data field width. Fixed at 16; the parameter exists for the package only.

Ports:
CLK  in  1  system clock, same domain as the controller's CLK.
RESET  in  1  synchronous, active-low reset.
MDC  in  1  management clock from the controller. It is CLK-synchronous, so no synchronizer is used.
MDIO_OUT  in  1  serial data from the controller.
MDIO_OE  in  1  controller drive enable. Informational only; the block asserts a collision flag if both sides drive.
MDIO_IN  out  1  serial read data to the controller.
MDIO_IN_OE  out  1  peripheral drive enable.
ADDR  out  5  register address (REGAD).
WR_DATA  out  16  write data.
WR_STB  out  1  one-CLK write strobe.
RD_STB  out  1  one-CLK read request.
RD_DATA  in  16  register-file read data, valid the CLK cycle after RD_STB.
BUS_COLL  out  1  sticky flag: MDIO_OE and MDIO_IN_OE were high in the same cycle. Cleared by reset.

Behaviour:
- Reset: sampled on the CLK rising edge while RESET=0. All outputs go to 0, state goes to IDLE, the bit counter goes to 0. A reset mid-frame drops MDIO_IN_OE on the next edge and no strobe is issued.
- MDC edges: mdc_q is registered every CLK. rise = MDC & ~mdc_q; fall = ~MDC & mdc_q. MDIO_OUT is sampled only on rise. MDIO_IN/MDIO_IN_OE change only on fall.
- Bit counter: 5-bit, incremented per rise inside a frame, wraps at 31 → 0 on returning to IDLE.
- FSM states:
  - IDLE: shift the sampled bit into a 2-bit window. The window equal to 01 → OP.
  - OP: 2 bits. 01 = write, 10 = read. 00 or 11 → IGNORE.
  - PHYAD: 5 bits MSB-first. Mismatch with PHY_ADDR → IGNORE after the 5th bit.
  - REGAD: 5 bits, then ADDR is updated.
    - Read: RD_STB pulses for the one CLK immediately after the 5th REGAD rise. RD_DATA is captured into the tx shift register on the following CLK.
  - TA: 2 bits.
    - Write: sampled TA values are ignored.
    - Read: on the fall ending TA bit 1, MDIO_IN_OE=1 and MDIO_IN=0.
  - WDATA: 16 rises, MSB-first into a shift register. On the 16th rise, WR_DATA is loaded and WR_STB pulses 1 CLK (same edge). → IDLE.
  - RDATA: each fall shifts out the next bit, MSB-first, 16 bits. On the fall after bit 0, MDIO_IN_OE=0 and MDIO_IN=0. → IDLE.
  - IGNORE: count rises until 32 frame bits are consumed (counter = 31). No strobes; MDIO_IN_OE stays 0. → IDLE.
- Latencies:
  - Write: WR_STB occurs 1 CLK after the MDC rise carrying the last data bit.
  - Read: the data MSB appears on the fall ending TA bit 2.
- Back-to-back frames: IDLE is re-entered the same CLK that a frame ends, so the ST of the next frame is detected with no gap.
- A rise and a fall cannot occur in the same CLK, so there are no simultaneous-event cases.

Optional Feature:
MDIO_PREAMBLE_EN
- Defined: IDLE additionally requires ≥32 consecutive sampled 1s before ST=01 is accepted. Any 0 before 32 ones clears the preamble count.
- Undefined: ST is accepted directly from IDLE with no preamble, which matches the current controller's framing.

Decomposition:
- Package mdio_pkg holds:
  - Opcode constants: OP_WR=2'b01, OP_RD=2'b10.
  - ST constant 2'b01.
  - Field widths: PHYAD 5, REGAD 5, TA 2, DATA 16, frame 32.
  - FSM state encoding.
- Sub-module mdio_edge_det (mdc_q register plus rise/fall outputs) is natural; the controller side reuses it.

Test Plan:
1. Write: frame {01,01,00001,00010,00,ABCD}. Expect exactly one WR_STB, ADDR=5'd2, WR_DATA=16'hABCD, MDIO_IN_OE=0 throughout.
2. Read: frame {01,10,00001,00100,TA,--} with RD_DATA=16'h1234 after RD_STB. Expect one RD_STB with ADDR=4. MDIO_IN_OE rises at the TA1 fall. MDIO_IN reads 0, then 0001_0010_0011_0100 on successive falls. OE drops after the last bit.
3. PHY mismatch: write to PHYAD=3 with data ABCD. Expect no WR_STB or RD_STB, MDIO_IN_OE=0. A following frame to PHYAD=1 is accepted.
4. Bad opcode: OP=11 frame, then a valid write of 16'h5A5A to REGAD 7. Expect the first frame ignored; the second gives WR_STB with WR_DATA=5A5A, ADDR=7.
5. Reset mid-read: RESET=0 during RDATA bit 8. Expect MDIO_IN_OE=0 and MDIO_IN=0 on the next CLK, state IDLE. After release, a read of REGAD 4 returns correct data.
6. With MDIO_PREAMBLE_EN: a write without preamble is ignored. The same write preceded by 32 ones gives WR_STB, WR_DATA=ABCD.
